// File: rtl/mem_access_pkg.sv
// mem_access_pkg: encodings and store-lane helpers shared by the mem_access stage.
// No ports. Provides the MemRW, MemBranch, dsize and FSM state encodings,
// the MEM/WB register layout, and the byte-enable / write-data lane builders.
package mem_access_pkg;

    typedef enum logic [1:0] {MEM_NONE = 2'b00, MEM_LOAD = 2'b01, MEM_STORE = 2'b10} memrw_e;
    typedef enum logic [2:0] {BR_NONE = 3'd0, BR_EQ = 3'd1, BR_NE = 3'd2, BR_LT = 3'd3, BR_GE = 3'd4, BR_JUMP = 3'd5} branch_e;
    typedef enum logic [1:0] {SZ_BYTE = 2'b00, SZ_HALF = 2'b01, SZ_WORD = 2'b10} dsize_e;
    typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, HOLD = 2'd2} state_e;

    typedef struct packed {
        logic [31:0] alu;
        logic [31:0] load_data;
        logic [31:0] pcp4;
        logic [4:0]  wreg;
        logic        regwrite;
        logic [1:0]  memtoreg;
    } mem_wb_t;

    // Halves take their lane pair from addr[1] only, so an unchecked misaligned half stays in its word.
    function automatic logic [3:0] store_be(input logic [1:0] dsize, input logic [1:0] off);
        return dsize == SZ_BYTE ? 4'b0001 << off : dsize == SZ_HALF ? 4'b0011 << {off[1], 1'b0} : 4'b1111;
    endfunction

    function automatic logic [31:0] store_wdata(input logic [1:0] dsize, input logic [31:0] data);
        return dsize == SZ_BYTE ? {4{data[7:0]}} : dsize == SZ_HALF ? {2{data[15:0]}} : data;
    endfunction

endpackage

// File: rtl/mem_access_load_align.sv
// mem_access_load_align: selects the load lane from a read word and extends it to 32 bits.
// Ports: rdata (memory word), off (addr[1:0]), dsize (byte/half/word),
//        is_unsigned (zero-extend when set), result (aligned, extended value).
module mem_access_load_align
    import mem_access_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  off,
    input  logic [1:0]  dsize,
    input  logic        is_unsigned,
    output logic [31:0] result
);

    logic [1:0]  lane;
    logic [15:0] shifted;

    always_comb begin
        lane = dsize == SZ_BYTE ? off : dsize == SZ_HALF ? {off[1], 1'b0} : 2'b00;
        shifted = 16'(rdata >> {lane, 3'b000});
        result = dsize == SZ_BYTE ? {{24{~is_unsigned & shifted[7]}}, shifted[7:0]} :
                 dsize == SZ_HALF ? {{16{~is_unsigned & shifted[15]}}, shifted[15:0]} : rdata;
    end

endmodule

// File: rtl/mem_access.sv
// mem_access: RV32I memory-access stage; resolves branches, runs the data-memory
// req/ack transaction for loads/stores, aligns load data and drives MEM/WB.
// Ports: clk, rst (sync, active-low); keep/nop hazard controls; EX/MEM inputs
// (*_pype/*_pype2); data bus dmem_req/we/addr/wdata/be out, dmem_rdata/ack in;
// mem_stall, branch_taken, PCBranch_out, misalign_fault; MEM/WB outputs (*_pype3).
// Optional: define MEM_MISALIGN_CHECK_EN to trap misaligned half/word accesses.
module mem_access
    import mem_access_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        keep,
    input  logic        nop,
    input  logic [31:0] ALU_co_pype,
    input  logic [31:0] read_data2_pype2,
    input  logic [31:0] PCBranch_pype2,
    input  logic [31:0] PCp4_pype2,
    input  logic [4:0]  WReg_pype2,
    input  logic        RegWrite_pype2,
    input  logic [1:0]  MemtoReg_pype2,
    input  logic [1:0]  MemRW_pype2,
    input  logic [2:0]  MemBranch_pype2,
    input  logic [1:0]  dsize_pype2,
    input  logic [2:0]  funct3_pype2,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        mem_stall,
    output logic        branch_taken,
    output logic [31:0] PCBranch_out,
    output logic        misalign_fault,
    output logic [31:0] ALU_co_pype3,
    output logic [31:0] load_data_pype3,
    output logic [31:0] PCp4_pype3,
    output logic [4:0]  WReg_pype3,
    output logic        RegWrite_pype3,
    output logic [1:0]  MemtoReg_pype3
);

    state_e      state, state_n;
    mem_wb_t     wb, wb_n, wb_buf, buf_n, wb_in;
    logic [31:0] aligned;
    logic        pending, misaligned, issue, alu_zero;
    logic        unused_funct3;

    assign unused_funct3 = ^funct3_pype2[1:0];

    mem_access_load_align u_load_align (
        .rdata       (dmem_rdata),
        .off         (ALU_co_pype[1:0]),
        .dsize       (dsize_pype2),
        .is_unsigned (funct3_pype2[2]),
        .result      (aligned)
    );

    assign pending = MemRW_pype2 != MEM_NONE && !nop;

`ifdef MEM_MISALIGN_CHECK_EN
    assign misaligned = dsize_pype2 == SZ_HALF ? ALU_co_pype[0] : dsize_pype2 != SZ_BYTE && ALU_co_pype[1:0] != 2'b00;
    always_ff @(posedge clk) misalign_fault <= rst && state == IDLE && pending && misaligned;
`else
    assign misaligned = 1'b0;
    assign misalign_fault = 1'b0;
`endif

    // A trapped misaligned access never issues, so it must not stall either or the pipe would deadlock.
    assign issue = state == IDLE && pending && !misaligned;
    assign mem_stall = issue || (state == ACCESS && !dmem_ack) || state == HOLD;
    assign dmem_req = state == ACCESS;

    assign alu_zero = ALU_co_pype == 32'd0;
    assign branch_taken = !nop && (MemBranch_pype2 == BR_JUMP ||
                          ((MemBranch_pype2 == BR_EQ || MemBranch_pype2 == BR_GE) && alu_zero) ||
                          ((MemBranch_pype2 == BR_NE || MemBranch_pype2 == BR_LT) && !alu_zero));
    assign PCBranch_out = PCBranch_pype2;

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else state <= state_n;
    end

    // The ack cycle releases the stall, so upstream may move on while keep parks
    // the completed load in wb_buf; HOLD then drains it once keep drops.
    always_comb begin
        wb_in = '{alu: ALU_co_pype, load_data: aligned, pcp4: PCp4_pype2, wreg: WReg_pype2,
                  regwrite: RegWrite_pype2, memtoreg: MemtoReg_pype2};
        state_n = state;
        wb_n = wb;
        buf_n = wb_buf;
        case (state)
            IDLE: begin
                state_n = issue ? ACCESS : IDLE;
                if (!keep) begin
                    wb_n = wb_in;
                    wb_n.load_data = 32'd0;
                    if (nop || pending) wb_n = '0;
                end
            end
            ACCESS: if (dmem_ack) begin
                state_n = keep ? HOLD : IDLE;
                if (keep) buf_n = wb_in;
                else wb_n = wb_in;
            end
            HOLD: if (!keep) begin
                state_n = IDLE;
                wb_n = wb_buf;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wb <= '0;
            wb_buf <= '0;
            dmem_addr <= '0;
            dmem_wdata <= '0;
            dmem_be <= '0;
            dmem_we <= 1'b0;
        end else begin
            wb <= wb_n;
            wb_buf <= buf_n;
            if (issue) begin
                dmem_addr <= {ALU_co_pype[31:2], 2'b00};
                dmem_wdata <= store_wdata(dsize_pype2, read_data2_pype2);
                dmem_be <= store_be(dsize_pype2, ALU_co_pype[1:0]);
                dmem_we <= MemRW_pype2 == MEM_STORE;
            end
        end
    end

    assign ALU_co_pype3 = wb.alu;
    assign load_data_pype3 = wb.load_data;
    assign PCp4_pype3 = wb.pcp4;
    assign WReg_pype3 = wb.wreg;
    assign RegWrite_pype3 = wb.regwrite;
    assign MemtoReg_pype3 = wb.memtoreg;

endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: self-checking bench for mem_access with a behavioural lane/extension model.
module tb_mem_access;

    logic        clk = 1'b0, rst = 1'b0, keep = 1'b0, nop = 1'b0;
    logic [31:0] ALU_co_pype = '0, read_data2_pype2 = '0, PCBranch_pype2 = '0, PCp4_pype2 = '0, dmem_rdata = '0;
    logic [4:0]  WReg_pype2 = '0;
    logic        RegWrite_pype2 = 1'b0, dmem_ack = 1'b0;
    logic [1:0]  MemtoReg_pype2 = '0, MemRW_pype2 = '0, dsize_pype2 = '0;
    logic [2:0]  MemBranch_pype2 = '0, funct3_pype2 = '0;
    logic        dmem_req, dmem_we, mem_stall, branch_taken, misalign_fault, RegWrite_pype3;
    logic [31:0] dmem_addr, dmem_wdata, PCBranch_out, ALU_co_pype3, load_data_pype3, PCp4_pype3;
    logic [3:0]  dmem_be;
    logic [4:0]  WReg_pype3;
    logic [1:0]  MemtoReg_pype3;
    int n_checks = 0, n_fail = 0;

    always #5 clk = ~clk;

    mem_access dut (
        .clk(clk), .rst(rst), .keep(keep), .nop(nop),
        .ALU_co_pype(ALU_co_pype), .read_data2_pype2(read_data2_pype2),
        .PCBranch_pype2(PCBranch_pype2), .PCp4_pype2(PCp4_pype2),
        .WReg_pype2(WReg_pype2), .RegWrite_pype2(RegWrite_pype2), .MemtoReg_pype2(MemtoReg_pype2),
        .MemRW_pype2(MemRW_pype2), .MemBranch_pype2(MemBranch_pype2),
        .dsize_pype2(dsize_pype2), .funct3_pype2(funct3_pype2),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
        .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .mem_stall(mem_stall), .branch_taken(branch_taken), .PCBranch_out(PCBranch_out),
        .misalign_fault(misalign_fault),
        .ALU_co_pype3(ALU_co_pype3), .load_data_pype3(load_data_pype3), .PCp4_pype3(PCp4_pype3),
        .WReg_pype3(WReg_pype3), .RegWrite_pype3(RegWrite_pype3), .MemtoReg_pype3(MemtoReg_pype3)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] exp_load(input logic [31:0] rd, input int off, input int sz, input logic uns);
        int bytes = 1 << sz;
        int lane = off - off % bytes;
        longint v;
        v = longint'(rd >> (8 * lane)) % (longint'(1) << (8 * bytes));
        if (!uns && bytes < 4 && v >= (longint'(1) << (8 * bytes - 1))) v -= longint'(1) << (8 * bytes);
        return v[31:0];
    endfunction

    function automatic logic [3:0] exp_be(input int off, input int sz);
        int bytes = 1 << sz;
        int lane = off - off % bytes;
        return 4'(((1 << bytes) - 1) << lane);
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [31:0] d, input int sz);
        return sz == 0 ? (d & 32'hFF) * 32'h01010101 : sz == 1 ? (d & 32'hFFFF) * 32'h00010001 : d;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        MemRW_pype2 = 2'b00; RegWrite_pype2 = 1'b0; MemBranch_pype2 = 3'd0;
        nop = 1'b0; keep = 1'b0; dmem_ack = 1'b0;
    endtask

    task automatic drive_mem(input logic [1:0] rw, input logic [31:0] a, input logic [1:0] sz, input logic uns,
                             input logic [31:0] wd, input logic [4:0] wr, input logic rw_en, input logic [31:0] pc);
        MemRW_pype2 = rw; ALU_co_pype = a; dsize_pype2 = sz; funct3_pype2 = {uns, 2'b00};
        read_data2_pype2 = wd; WReg_pype2 = wr; RegWrite_pype2 = rw_en; MemtoReg_pype2 = 2'b01; PCp4_pype2 = pc;
        nop = 1'b0; keep = 1'b0;
    endtask

    task automatic test_reset();
        drive_idle();
        rst = 1'b0;
        step();
        step();
        n_checks++;
        if ({ALU_co_pype3, load_data_pype3, PCp4_pype3, WReg_pype3, RegWrite_pype3, MemtoReg_pype3} !== '0) begin
            n_fail++; $display("FAIL reset_memwb: got %h/%h/%h/%0d/%0d/%0d required all 0", ALU_co_pype3,
                               load_data_pype3, PCp4_pype3, WReg_pype3, RegWrite_pype3, MemtoReg_pype3);
        end
        n_checks++;
        if ({dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be, misalign_fault, mem_stall} !== '0) begin
            n_fail++; $display("FAIL reset_bus: req=%0d we=%0d addr=%h wdata=%h be=%b fault=%0d stall=%0d required all 0",
                               dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be, misalign_fault, mem_stall);
        end
        rst = 1'b1;
        step();
    endtask

    task automatic test_alu_pass();
        logic [31:0] e_alu = '0, e_pc = '0;
        logic [4:0]  e_wr = '0;
        logic [1:0]  e_mt = '0;
        logic        e_rw = 1'b0, full = 1'b0;
        for (int i = 0; i < 24; i++) begin
            drive_mem(2'b00, $urandom, 2'($urandom_range(0, 2)), 1'b0, $urandom, 5'($urandom_range(0, 31)),
                      1'($urandom_range(0, 1)), $urandom);
            MemtoReg_pype2 = 2'($urandom_range(0, 3));
            keep = i > 0 && $urandom_range(0, 3) == 0;
            nop = i > 0 && $urandom_range(0, 3) == 0;
            if (!keep && nop) begin e_rw = 1'b0; full = 1'b0; end
            else if (!keep) begin
                e_alu = ALU_co_pype; e_pc = PCp4_pype2; e_wr = WReg_pype2; e_mt = MemtoReg_pype2;
                e_rw = RegWrite_pype2; full = 1'b1;
            end
            #1;
            n_checks++;
            if (mem_stall !== 1'b0) begin n_fail++; $display("FAIL alu_stall[%0d]: got %0d required 0", i, mem_stall); end
            step();
            n_checks++;
            if (RegWrite_pype3 !== e_rw) begin
                n_fail++; $display("FAIL alu_regwrite[%0d]: got %0d required %0d", i, RegWrite_pype3, e_rw);
            end
            if (full) begin
                n_checks++;
                if ({ALU_co_pype3, PCp4_pype3, WReg_pype3, MemtoReg_pype3} !== {e_alu, e_pc, e_wr, e_mt}) begin
                    n_fail++; $display("FAIL alu_fields[%0d]: got %h %h %0d %0d required %h %h %0d %0d", i, ALU_co_pype3,
                                       PCp4_pype3, WReg_pype3, MemtoReg_pype3, e_alu, e_pc, e_wr, e_mt);
                end
            end
        end
        drive_idle();
        step();
    endtask

    task automatic test_load();
        for (int i = 0; i < 12; i++) begin
            logic [31:0] a, rd, pc, e;
            logic [1:0]  sz;
            logic [4:0]  wr;
            logic        uns;
            int          d, stalls;
            sz = 2'($urandom_range(0, 2));
            a = 32'h100 + ($urandom_range(0, 255) << 2);
            a = a + (sz == 0 ? $urandom_range(0, 3) : sz == 1 ? 2 * $urandom_range(0, 1) : 0);
            rd = $urandom; d = $urandom_range(0, 3); uns = 1'($urandom_range(0, 1));
            wr = 5'($urandom_range(1, 31)); pc = $urandom;
            if (i == 0) begin a = 32'h100; sz = 2'b10; uns = 1'b0; rd = 32'h12345678; d = 3; end
            if (i == 1 || i == 2) begin a = 32'h103; sz = 2'b00; uns = i == 2; rd = 32'h80000000; end
            e = i == 0 ? 32'h12345678 : i == 1 ? 32'hFFFFFF80 : i == 2 ? 32'h00000080 : exp_load(rd, a % 4, sz, uns);
            drive_mem(2'b01, a, sz, uns, $urandom, wr, 1'b1, pc);
            stalls = 0;
            #1;
            if (mem_stall) stalls++;
            step();
            n_checks++;
            if ({dmem_req, dmem_we, dmem_addr, RegWrite_pype3} !== {1'b1, 1'b0, a & ~32'd3, 1'b0}) begin
                n_fail++; $display("FAIL load_access[%0d]: req=%0d we=%0d addr=%h rw3=%0d required 1 0 %h 0", i,
                                   dmem_req, dmem_we, dmem_addr, RegWrite_pype3, a & ~32'd3);
            end
            for (int k = 0; k < d; k++) begin
                if (mem_stall) stalls++;
                step();
            end
            dmem_ack = 1'b1; dmem_rdata = rd;
            #1;
            if (mem_stall) stalls++;
            step();
            dmem_ack = 1'b0; dmem_rdata = $urandom;
            n_checks++;
            if (stalls != 1 + d) begin n_fail++; $display("FAIL load_stall_cycles[%0d]: got %0d required %0d", i, stalls, 1 + d); end
            n_checks++;
            if (load_data_pype3 !== e) begin n_fail++; $display("FAIL load_data[%0d]: got %h required %h", i, load_data_pype3, e); end
            n_checks++;
            if ({RegWrite_pype3, WReg_pype3, PCp4_pype3, ALU_co_pype3, dmem_req} !== {1'b1, wr, pc, a, 1'b0}) begin
                n_fail++; $display("FAIL load_wb[%0d]: rw=%0d wr=%0d pc=%h alu=%h req=%0d required 1 %0d %h %h 0", i,
                                   RegWrite_pype3, WReg_pype3, PCp4_pype3, ALU_co_pype3, dmem_req, wr, pc, a);
            end
            drive_idle();
        end
        step();
    endtask

    task automatic test_store();
        for (int i = 0; i < 10; i++) begin
            logic [31:0] a, wd;
            logic [1:0]  sz;
            int          d;
            sz = 2'($urandom_range(0, 2));
            a = 32'h400 + ($urandom_range(0, 255) << 2);
            a = a + (sz == 0 ? $urandom_range(0, 3) : sz == 1 ? 2 * $urandom_range(0, 1) : 0);
            wd = $urandom; d = $urandom_range(0, 2);
            if (i == 0) begin a = 32'h102; sz = 2'b00; wd = 32'h000000AB; end
            drive_mem(2'b10, a, sz, 1'b0, wd, 5'd0, 1'b0, $urandom);
            #1;
            step();
            n_checks++;
            if ({dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata} !==
                {1'b1, 1'b1, a & ~32'd3, exp_be(a % 4, sz), exp_wdata(wd, sz)}) begin
                n_fail++; $display("FAIL store_bus[%0d]: req=%0d we=%0d addr=%h be=%b wdata=%h required 1 1 %h %b %h", i,
                                   dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, a & ~32'd3, exp_be(a % 4, sz), exp_wdata(wd, sz));
            end
            if (i == 0) begin
                n_checks++;
                if ({dmem_be, dmem_wdata} !== {4'b0100, 32'hABABABAB}) begin
                    n_fail++; $display("FAIL sb_0x102: be=%b wdata=%h required 0100 abababab", dmem_be, dmem_wdata);
                end
            end
            for (int k = 0; k < d; k++) step();
            dmem_ack = 1'b1;
            #1;
            n_checks++;
            if ({dmem_req, mem_stall, dmem_wdata} !== {1'b1, 1'b0, exp_wdata(wd, sz)}) begin
                n_fail++; $display("FAIL store_ack[%0d]: req=%0d stall=%0d wdata=%h required 1 0 %h", i,
                                   dmem_req, mem_stall, dmem_wdata, exp_wdata(wd, sz));
            end
            step();
            drive_idle();
            n_checks++;
            if ({dmem_req, RegWrite_pype3} !== 2'b00) begin
                n_fail++; $display("FAIL store_done[%0d]: req=%0d rw3=%0d required 0 0", i, dmem_req, RegWrite_pype3);
            end
        end
        step();
    endtask

    task automatic test_branch();
        for (int i = 0; i < 20; i++) begin
            logic [31:0] alu, tgt;
            int          code;
            logic        nb, e;
            alu = $urandom_range(0, 1) ? 32'd0 : $urandom;
            code = $urandom_range(0, 5); nb = $urandom_range(0, 4) == 0; tgt = $urandom;
            if (i < 2) begin alu = 32'd0; code = i + 1; nb = 1'b0; end
            MemBranch_pype2 = 3'(code); ALU_co_pype = alu; nop = nb; PCBranch_pype2 = tgt;
            e = !nb && (code == 5 || ((code == 1 || code == 4) && alu == 0) || ((code == 2 || code == 3) && alu != 0));
            #1;
            n_checks++;
            if ({branch_taken, PCBranch_out} !== {e, tgt}) begin
                n_fail++; $display("FAIL branch[%0d] code=%0d alu=%h nop=%0d: taken=%0d pc=%h required %0d %h", i, code,
                                   alu, nb, branch_taken, PCBranch_out, e, tgt);
            end
        end
        drive_idle();
        step();
    endtask

    task automatic test_keep_hold();
        logic [31:0] rd = $urandom, alu2 = $urandom, pc = $urandom;
        drive_mem(2'b01, 32'h180, 2'b10, 1'b0, 32'd0, 5'd9, 1'b1, pc);
        #1;
        step();
        keep = 1'b1; dmem_ack = 1'b1; dmem_rdata = rd;
        #1;
        n_checks++;
        if (mem_stall !== 1'b0) begin n_fail++; $display("FAIL keep_ack_stall: got %0d required 0", mem_stall); end
        step();
        dmem_ack = 1'b0; dmem_rdata = $urandom;
        drive_mem(2'b00, alu2, 2'b10, 1'b0, 32'd0, 5'd12, 1'b1, 32'h44);
        keep = 1'b1;
        for (int k = 0; k < 2; k++) begin
            #1;
            n_checks++;
            if ({mem_stall, RegWrite_pype3, dmem_req} !== 3'b100) begin
                n_fail++; $display("FAIL hold_state[%0d]: stall=%0d rw3=%0d req=%0d required 1 0 0", k, mem_stall,
                                   RegWrite_pype3, dmem_req);
            end
            step();
        end
        keep = 1'b0;
        #1;
        n_checks++;
        if (mem_stall !== 1'b1) begin n_fail++; $display("FAIL hold_release_stall: got %0d required 1", mem_stall); end
        step();
        n_checks++;
        if ({load_data_pype3, WReg_pype3, RegWrite_pype3, PCp4_pype3} !== {rd, 5'd9, 1'b1, pc}) begin
            n_fail++; $display("FAIL hold_drain: data=%h wr=%0d rw=%0d pc=%h required %h 9 1 %h", load_data_pype3,
                               WReg_pype3, RegWrite_pype3, PCp4_pype3, rd, pc);
        end
        n_checks++;
        if (mem_stall !== 1'b0) begin n_fail++; $display("FAIL hold_after_stall: got %0d required 0", mem_stall); end
        step();
        n_checks++;
        if ({ALU_co_pype3, WReg_pype3} !== {alu2, 5'd12}) begin
            n_fail++; $display("FAIL hold_next_instr: alu=%h wr=%0d required %h 12", ALU_co_pype3, WReg_pype3, alu2);
        end
        drive_idle();
        step();
    endtask

    task automatic test_reset_access();
        drive_mem(2'b01, 32'h200, 2'b10, 1'b0, 32'd0, 5'd3, 1'b1, 32'h10);
        #1;
        step();
        n_checks++;
        if (dmem_req !== 1'b1) begin n_fail++; $display("FAIL rst_pre_req: got %0d required 1", dmem_req); end
        rst = 1'b0; dmem_ack = 1'b1; dmem_rdata = 32'hDEADBEEF;
        step();
        n_checks++;
        if ({dmem_req, dmem_addr, dmem_be, dmem_we, RegWrite_pype3, load_data_pype3, ALU_co_pype3} !== '0) begin
            n_fail++; $display("FAIL rst_in_access: req=%0d addr=%h be=%b we=%0d rw3=%0d data=%h alu=%h required all 0",
                               dmem_req, dmem_addr, dmem_be, dmem_we, RegWrite_pype3, load_data_pype3, ALU_co_pype3);
        end
        drive_idle();
        rst = 1'b1;
        step();
        n_checks++;
        if ({dmem_req, mem_stall, RegWrite_pype3} !== 3'b000) begin
            n_fail++; $display("FAIL rst_recover: req=%0d stall=%0d rw3=%0d required 0 0 0", dmem_req, mem_stall, RegWrite_pype3);
        end
    endtask

    task automatic test_misalign();
        logic [31:0] rd = $urandom;
        drive_mem(2'b00, 32'h55, 2'b10, 1'b0, 32'd0, 5'd4, 1'b1, 32'h20);
        step();
        drive_mem(2'b01, 32'h102, 2'b10, 1'b0, 32'd0, 5'd5, 1'b1, 32'h24);
`ifdef MEM_MISALIGN_CHECK_EN
        step();
        drive_idle();
        n_checks++;
        if ({misalign_fault, dmem_req, RegWrite_pype3} !== 3'b100) begin
            n_fail++; $display("FAIL misalign_trap: fault=%0d req=%0d rw3=%0d required 1 0 0", misalign_fault, dmem_req, RegWrite_pype3);
        end
        step();
        n_checks++;
        if ({misalign_fault, dmem_req} !== 2'b00) begin
            n_fail++; $display("FAIL misalign_pulse: fault=%0d req=%0d required 0 0", misalign_fault, dmem_req);
        end
`else
        #1;
        step();
        n_checks++;
        if ({misalign_fault, dmem_req, dmem_addr} !== {1'b0, 1'b1, 32'h100}) begin
            n_fail++; $display("FAIL misalign_off: fault=%0d req=%0d addr=%h required 0 1 00000100", misalign_fault,
                               dmem_req, dmem_addr);
        end
        dmem_ack = 1'b1; dmem_rdata = rd;
        step();
        drive_idle();
        n_checks++;
        if ({load_data_pype3, misalign_fault} !== {rd, 1'b0}) begin
            n_fail++; $display("FAIL misalign_off_data: data=%h fault=%0d required %h 0", load_data_pype3, misalign_fault, rd);
        end
`endif
        step();
    endtask

    initial begin
        test_reset();
        test_alu_pass();
        test_load();
        test_store();
        test_branch();
        test_keep_hold();
        test_reset_access();
        test_misalign();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
